// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the status producers, the arbiter and the UART transmitter.
// master = arbiter side, slave = producers/transmitter side.
`timescale 1ns/1ps
interface uart_tx_arbiter_if #(
    parameter int unsigned N_REQ = 3,
    parameter int unsigned W_OUT = 24,
    parameter int unsigned ID_W  = $clog2(N_REQ)
);
    logic [N_REQ-1:0]       s_mask;
    logic [N_REQ-1:0]       s_valid;
    logic [N_REQ*W_OUT-1:0] s_data;
    logic [N_REQ-1:0]       s_ready;
    logic                   m_valid;
    logic [W_OUT-1:0]       m_data;
    logic [ID_W-1:0]        m_id;
    logic                   m_ready;

    modport master (
        input  s_mask, s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_id
    );

    modport slave (
        output s_mask, s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_id
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with burst limit sharing one UART transmitter between N_REQ producers;
// the winning frame is captured into a one-entry hold register and offered downstream with its ID.
`timescale 1ns/1ps
module uart_tx_arbiter #(
    parameter int unsigned N_REQ     = 3,
    parameter int unsigned W_OUT     = 24,
    parameter int unsigned MAX_BURST = 2,
    parameter int unsigned ID_W      = $clog2(N_REQ)
) (
    input  logic              clk,
    input  logic              rstn,
    uart_tx_arbiter_if.master bus
);
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OFFER = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [W_OUT-1:0] hold_q,  hold_d;
    logic [ID_W-1:0]  id_q,    id_d;
    logic [ID_W-1:0]  ptr_q,   ptr_d;
    logic [ID_W-1:0]  last_q,  last_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic [N_REQ-1:0] elig;
    logic             gnt_vld;
    logic [ID_W-1:0]  gnt_id;
    logic [ID_W-1:0]  gnt_nxt;
    logic [CNT_W-1:0] cnt_new;

    // First eligible index searching ptr, ptr+1, ... modulo N_REQ; only in IDLE.
    always_comb begin : search
        int unsigned k;
        k       = 0;
        elig    = bus.s_valid & bus.s_mask;
        gnt_vld = 1'b0;
        gnt_id  = '0;
        if (state_q == ST_IDLE) begin
            for (int unsigned off = 0; off < N_REQ; off++) begin
                k = (32'(ptr_q) + off) % N_REQ;
                if (!gnt_vld && elig[ID_W'(k)]) begin
                    gnt_vld = 1'b1;
                    gnt_id  = ID_W'(k);
                end
            end
        end
    end

    always_comb begin : strobe
        bus.s_ready = '0;
        if (gnt_vld) begin
            bus.s_ready[gnt_id] = 1'b1;
        end
    end

    always_comb begin : bookkeeping
        gnt_nxt = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
        cnt_new = (gnt_id == last_q && cnt_q != '0) ? cnt_q + 1'b1 : CNT_W'(1);
    end

    always_comb begin : next_state
        state_d = state_q;
        hold_d  = hold_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_vld) begin
                    hold_d  = bus.s_data[gnt_id*W_OUT +: W_OUT];
                    id_d    = gnt_id;
                    state_d = ST_OFFER;
                    last_d  = gnt_id;
                    // Burst exhausted: priority moves past the winner.
                    if (cnt_new == CNT_W'(MAX_BURST)) begin
                        ptr_d = gnt_nxt;
                        cnt_d = '0;
                    end else begin
                        ptr_d = gnt_id;
                        cnt_d = cnt_new;
                    end
                end
            end
            ST_OFFER: begin
                if (bus.m_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
            last_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.m_valid = (state_q == ST_OFFER);
    assign bus.m_data  = hold_q;
    assign bus.m_id    = id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter: one instance with burst limit 2,
// one with pure round-robin (burst limit 1).
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    localparam int unsigned N   = 3;
    localparam int unsigned W   = 24;
    localparam int unsigned IDW = 2;

    logic clk = 1'b0;
    logic rstn;
    int   checks = 0;
    int   errors = 0;

    logic [W-1:0] dat_b [3] = '{24'h0A0A0A, 24'hA5C3F0, 24'h0C0C0C};
    logic [W-1:0] dat_r [3] = '{24'h111111, 24'h222222, 24'h333333};
    int           rr_ord [6] = '{0, 1, 2, 0, 1, 2};
    int           bu_ord [6] = '{0, 0, 2, 2, 0, 0};

    uart_tx_arbiter_if #(.N_REQ(N), .W_OUT(W), .ID_W(IDW)) bi ();
    uart_tx_arbiter_if #(.N_REQ(N), .W_OUT(W), .ID_W(IDW)) br ();

    uart_tx_arbiter #(.N_REQ(N), .W_OUT(W), .MAX_BURST(2), .ID_W(IDW)) u_dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bi)
    );

    uart_tx_arbiter #(.N_REQ(N), .W_OUT(W), .MAX_BURST(1), .ID_W(IDW)) u_rr (
        .clk  (clk),
        .rstn (rstn),
        .bus  (br)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        bi.s_mask = '0; bi.s_valid = '0; bi.s_data = '0; bi.m_ready = 1'b0;
        br.s_mask = '0; br.s_valid = '0; br.s_data = '0; br.m_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0;
        clear_inputs();
        #1;
        chk("rst_m_valid", bi.m_valid, 0);
        chk("rst_m_data",  bi.m_data,  0);
        chk("rst_m_id",    bi.m_id,    0);
        chk("rst_s_ready", bi.s_ready, 0);
        chk("rst_rr_m_valid", br.m_valid, 0);

        // Pure round-robin, all valid, transmitter always ready
        do_reset();
        br.s_mask  = 3'b111;
        br.s_valid = 3'b111;
        br.s_data  = {dat_r[2], dat_r[1], dat_r[0]};
        br.m_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("rr_sready%0d", i), br.s_ready, 32'd1 << rr_ord[i]);
            @(negedge clk); #1;
            chk($sformatf("rr_mvalid%0d", i), br.m_valid, 1);
            chk($sformatf("rr_mid%0d", i),    br.m_id,    rr_ord[i]);
            chk($sformatf("rr_mdata%0d", i),  br.m_data,  dat_r[rr_ord[i]]);
            chk($sformatf("rr_sready_off%0d", i), br.s_ready, 0);
            @(negedge clk);
        end
        br.s_valid = '0;

        // Single requester
        do_reset();
        bi.s_mask  = 3'b111;
        bi.s_valid = 3'b010;
        bi.s_data  = {dat_b[2], dat_b[1], dat_b[0]};
        bi.m_ready = 1'b1;
        #1;
        chk("single_sready", bi.s_ready, 3'b010);
        @(posedge clk); #1;
        bi.s_valid = '0;
        @(negedge clk); #1;
        chk("single_mvalid", bi.m_valid, 1);
        chk("single_mdata",  bi.m_data,  24'hA5C3F0);
        chk("single_mid",    bi.m_id,    1);
        @(negedge clk); #1;
        chk("single_mvalid_drop", bi.m_valid, 0);
        chk("single_hold_kept",   bi.m_data,  24'hA5C3F0);
        chk("single_sready_idle", bi.s_ready, 0);

        // Burst limit 2 with requesters 0 and 2, ptr wraps 2 -> 0
        do_reset();
        bi.s_mask  = 3'b111;
        bi.s_valid = 3'b101;
        bi.s_data  = {dat_b[2], dat_b[1], dat_b[0]};
        bi.m_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("burst_sready%0d", i), bi.s_ready, 32'd1 << bu_ord[i]);
            @(negedge clk); #1;
            chk($sformatf("burst_mid%0d", i),   bi.m_id,   bu_ord[i]);
            chk($sformatf("burst_mdata%0d", i), bi.m_data, dat_b[bu_ord[i]]);
            @(negedge clk);
        end

        // Backpressure: 50 cycles with m_ready low
        do_reset();
        bi.s_mask  = 3'b111;
        bi.s_valid = 3'b111;
        bi.s_data  = {dat_b[2], dat_b[1], dat_b[0]};
        bi.m_ready = 1'b0;
        #1;
        chk("bp_sready_cap", bi.s_ready, 3'b001);
        @(negedge clk);
        for (int i = 0; i < 50; i++) begin
            #1;
            chk($sformatf("bp_mvalid%0d", i), bi.m_valid, 1);
            chk($sformatf("bp_mdata%0d", i),  bi.m_data,  dat_b[0]);
            chk($sformatf("bp_mid%0d", i),    bi.m_id,    0);
            chk($sformatf("bp_sready%0d", i), bi.s_ready, 0);
            @(negedge clk);
        end
        bi.m_ready = 1'b1;
        #1;
        chk("bp_mvalid_at_rise", bi.m_valid, 1);
        @(negedge clk); #1;
        chk("bp_accepted", bi.m_valid, 0);
        chk("bp_next_grant", bi.s_ready, 3'b001);

        // Mask 101: requester 1 never granted, then full mask with a frame in flight
        do_reset();
        bi.s_mask  = 3'b101;
        bi.s_valid = 3'b111;
        bi.s_data  = {dat_b[2], dat_b[1], dat_b[0]};
        bi.m_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("mask_sready%0d", i), bi.s_ready, 32'd1 << bu_ord[i]);
            @(negedge clk); #1;
            chk($sformatf("mask_mid%0d", i), bi.m_id, bu_ord[i]);
            @(negedge clk);
        end
        #1;
        chk("mask_sready_last", bi.s_ready, 3'b100);
        bi.m_ready = 1'b0;
        @(negedge clk); #1;
        chk("mask_held_mvalid", bi.m_valid, 1);
        bi.s_mask = 3'b000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk($sformatf("mask0_mvalid%0d", i), bi.m_valid, 1);
            chk($sformatf("mask0_mid%0d", i),    bi.m_id,    2);
            chk($sformatf("mask0_mdata%0d", i),  bi.m_data,  dat_b[2]);
            chk($sformatf("mask0_sready%0d", i), bi.s_ready, 0);
        end
        bi.m_ready = 1'b1;
        @(negedge clk); #1;
        chk("mask0_delivered", bi.m_valid, 0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("mask0_idle_sready%0d", i), bi.s_ready, 0);
            @(negedge clk); #1;
        end

        // Asynchronous reset while offering
        do_reset();
        bi.s_mask  = 3'b111;
        bi.s_valid = 3'b100;
        bi.s_data  = {dat_b[2], dat_b[1], dat_b[0]};
        bi.m_ready = 1'b0;
        #1;
        chk("rmid_sready_cap", bi.s_ready, 3'b100);
        @(negedge clk); #1;
        chk("rmid_mvalid", bi.m_valid, 1);
        chk("rmid_mdata",  bi.m_data,  dat_b[2]);
        rstn = 1'b0;
        #1;
        chk("rmid_async_mvalid", bi.m_valid, 0);
        chk("rmid_async_mdata",  bi.m_data,  0);
        chk("rmid_async_mid",    bi.m_id,    0);
        #1;
        rstn       = 1'b1;
        bi.s_valid = 3'b111;
        #1;
        chk("rmid_first_search", bi.s_ready, 3'b001);
        @(negedge clk); #1;
        chk("rmid_first_mid",   bi.m_id,   0);
        chk("rmid_first_mdata", bi.m_data, dat_b[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
